// File: rtl/led_breathe_pkg.sv
// Shared constants and FSM state encoding for the LED breathing engine.
package led_breathe_pkg;

  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_STEP_PERIODS = 92;
  localparam int DEF_HOLD_PERIODS = 4688;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator: free-running period counter, per-period duty latch and
// registered compare, plus a one-clock tick after every counter wrap.
module led_pwm_gen
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_out,
  output logic                tick
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                wrap;

  assign wrap = enable && (pwm_cnt == '1);

  // Duty only changes at the wrap, so a period is never cut short or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!enable) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_out <= (pwm_cnt < duty);
      tick    <= wrap;
      if (wrap) begin
        duty <= brightness;
      end
    end
  end

endmodule

// File: rtl/led_breathe.sv
// Breathing LED driver: FSM ramps the PWM brightness up, holds, ramps down
// and holds, counting PWM periods; pulses cycle_done once per full breath.
module led_breathe
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int STEP_PERIODS = DEF_STEP_PERIODS,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] brightness,
  output logic                cycle_done
);

  localparam int CNT_W = $clog2(max_int(STEP_PERIODS, HOLD_PERIODS) + 1);
  localparam logic [CNT_W-1:0]    STEP_LAST  = CNT_W'(STEP_PERIODS - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;
  localparam logic [PWM_BITS-1:0] BRIGHT_PRE = BRIGHT_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] BRIGHT_ONE = PWM_BITS'(1);

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic             tick;

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .brightness (brightness),
    .led_out    (led_out),
    .tick       (tick)
  );

  // Reaching an end value leaves the ramp on the same tick, so no extra step is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      brightness <= '0;
      period_cnt <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        brightness <= '0;
        period_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= RAMP_UP;
            brightness <= '0;
            period_cnt <= '0;
          end
          RAMP_UP: begin
            if (tick) begin
              if (period_cnt == STEP_LAST) begin
                period_cnt <= '0;
                if (brightness != BRIGHT_MAX) begin
                  brightness <= brightness + 1'b1;
                end
                if (brightness >= BRIGHT_PRE) begin
                  state <= HOLD_HI;
                end
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
          end
          HOLD_HI: begin
            if (tick) begin
              if (period_cnt == HOLD_LAST) begin
                period_cnt <= '0;
                state      <= RAMP_DN;
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
          end
          RAMP_DN: begin
            if (tick) begin
              if (period_cnt == STEP_LAST) begin
                period_cnt <= '0;
                if (brightness != '0) begin
                  brightness <= brightness - 1'b1;
                end
                if (brightness <= BRIGHT_ONE) begin
                  state <= HOLD_LO;
                end
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
          end
          HOLD_LO: begin
            if (tick) begin
              if (period_cnt == HOLD_LAST) begin
                period_cnt <= '0;
                state      <= RAMP_UP;
                cycle_done <= 1'b1;
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
          end
          default: begin
            state      <= IDLE;
            brightness <= '0;
            period_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe at PWM_BITS=3, STEP=1, HOLD=2 (8-clock PWM period).
module tb_led_breathe;

  localparam int PWM_BITS     = 3;
  localparam int STEP_PERIODS = 1;
  localparam int HOLD_PERIODS = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                led_out;
  logic                cycle_done;
  logic [PWM_BITS-1:0] brightness;

  int vector_cnt = 0;
  int miscompare_cnt = 0;

  // Brightness per 8-clock window after enable; one 144-clock breath is 18 windows.
  int bright_table [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  always #5 clk = ~clk;

  led_breathe #(
    .PWM_BITS     (PWM_BITS),
    .STEP_PERIODS (STEP_PERIODS),
    .HOLD_PERIODS (HOLD_PERIODS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .led_out    (led_out),
    .brightness (brightness),
    .cycle_done (cycle_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_cnt++;
    if (observed !== expected) begin
      miscompare_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepClock(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Call at a negedge with the engine idle; n counts clocks since enable rose.
  task automatic applyStimulus(input int steps);
    int led_hi;
    int win;
    led_hi = 0;
    enable = 1'b1;
    for (int n = 1; n <= steps; n++) begin
      @(posedge clk);
      @(negedge clk);
      win = (n - 1) / 8;
      checkOutput("brightness", 32'(brightness), bright_table[win % 18]);
      checkOutput("cycle_done", 32'(cycle_done), (n > 1 && n % 144 == 1) ? 1 : 0);
      if (led_out === 1'b1) led_hi++;
      if (n % 8 == 0) begin
        checkOutput("led_high_clks", led_hi, bright_table[(win + 17) % 18]);
        led_hi = 0;
      end
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_led"}, 32'(led_out), 0);
    checkOutput({tag, "_bright"}, 32'(brightness), 0);
    checkOutput({tag, "_done"}, 32'(cycle_done), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    stepClock(2);
    checkIdleOutputs("idle_disabled");

    // Two full breaths plus one window: ramps, holds and cycle_done spacing.
    applyStimulus(296);
    enable = 1'b0;
    stepClock(1);
    checkIdleOutputs("disable_after_breath");
    stepClock(3);

    // Disable at brightness 4 while the LED is high within the period.
    applyStimulus(34);
    checkOutput("led_before_disable", 32'(led_out), 1);
    enable = 1'b0;
    stepClock(1);
    checkIdleOutputs("disable_mid_period");
    for (int i = 0; i < 4; i++) begin
      stepClock(1);
      checkIdleOutputs("disabled_hold");
    end

    // Restart from zero, then assert reset mid-ramp with the LED high.
    applyStimulus(17);
    checkOutput("led_before_reset", 32'(led_out), 1);
    checkOutput("bright_before_reset", 32'(brightness), 2);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    stepClock(2);
    checkIdleOutputs("reset_held");
    rst_n = 1'b1;
    applyStimulus(24);

    $display("== %0d vectors applied, %0d miscompares ==", vector_cnt, miscompare_cnt);
    $finish;
  end

endmodule
